uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- UART receiver; the receive-side counterpart to the divided baud clock that paces the serial transmit path.
- Runs entirely on the 50 MHz system clock, with its own internal bit-period counter; it does not use a divided clock.
- Synchronises the asynchronous rxd line and detects the start bit.
- Samples each data bit at mid-bit and checks the stop bit (and parity, when enabled).
- Presents one received byte per frame with a single-cycle valid strobe to downstream logic, e.g. the ADC command decoder.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (5208 at defaults), clocks per bit period; integer division, truncated.
- PARITY_EN, 0, 1 = a parity bit is expected between D7 and the stop bit.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low: rst=0 at a rising clk edge resets the block.
- rxd  input  1  asynchronous serial input; idles high.
- rx_data  output  8  last received byte, LSB first on the line.
- rx_valid  output  1  one-cycle pulse, rx_data is new.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (0 when PARITY_EN=0).
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0): state=IDLE, bit counter=0, clock counter=0, synchroniser FFs=1, rx_data=8'h00; rx_valid, frame_err, parity_err, busy all 0.
  - Reset mid-frame aborts the frame immediately; no strobe is issued for it.
- Synchroniser: two flip-flops, preset 1; rxd_s is the second stage. All decisions use rxd_s (2-cycle input latency).
- Clock counter: 0..CLKS_PER_BIT-1. It is cleared on every state entry and on every bit boundary.
- State machine:
  - IDLE: busy=0. If rxd_s==0, go to START with counter=0.
  - START: when counter reaches CLKS_PER_BIT/2-1, re-check rxd_s.
    - rxd_s==0: start is valid; clear counter, bit index=0, go to DATA.
    - rxd_s==1: glitch; return to IDLE with no strobe.
  - DATA: when counter reaches CLKS_PER_BIT-1 (the mid-point of the bit), shift rxd_s into shift register bit [index] (LSB first) and clear counter.
    - After index 7, go to PARITY if PARITY_EN, else STOP; otherwise index+1.
  - PARITY: at CLKS_PER_BIT-1, capture the parity bit and go to STOP.
  - STOP: at CLKS_PER_BIT-1, sample rxd_s and go to DONE.
  - DONE (one cycle):
    - rx_data <= shift register.
    - rx_valid=1 when the stop bit is 1 and parity is OK.
    - frame_err=1 when the stop bit is 0.
    - parity_err=1 on mismatch.
    - Return to IDLE.
- Error handling:
  - Frame or parity error: rx_valid stays 0, but rx_data is still updated.
  - Both errors in one frame: both flags pulse together.
- After DONE, IDLE waits for rxd_s high→low. If rxd_s is still low (stop bit low / break), no new frame starts until the line has been sampled high at least once.
- Strobe timing: strobes are asserted exactly 1 cycle after the stop sample point, and only ever for one cycle.
- rx_data holds its value between frames.
- Latency: the falling edge on rxd to rx_valid is 2 + CLKS_PER_BIT/2 + (9 + PARITY_EN)·CLKS_PER_BIT + 1 clocks, ±1.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. The half-bit sample margin absorbs the DONE cycle.
- Counter widths: sized for CLKS_PER_BIT up to 2^20; no wrap is possible within a state.

Test Plan:
(All scenarios use the override CLK_FREQ=1600, BAUD_RATE=100, giving CLKS_PER_BIT=16.)
- Byte 8'hA5 with a valid stop bit → one rx_valid pulse, rx_data=8'hA5, frame_err=0, busy high for the frame; latency 2+8+9·16+1 clocks ±1.
- Frames 8'h00, 8'hFF and 8'h3C sent back-to-back with no idle gap → three rx_valid pulses carrying 8'h00, 8'hFF, 8'h3C in order.
- 8'h55 with the stop bit driven low → frame_err one-cycle pulse, rx_valid=0, rx_data=8'h55; the block stays IDLE until rxd returns high.
- 4-clock low glitch on idle rxd → no strobes; busy pulses, then returns to 0 within 12 clocks.
- PARITY_EN=1, PARITY_ODD=0, byte 8'h07:
  - parity bit 1 → rx_valid, parity_err=0.
  - parity bit 0 → parity_err pulse, no rx_valid.
- rst driven low during data bit 4 of a frame → all outputs return to reset values on the next edge; no strobe for that frame; the next full frame 8'h81 is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-FF synchronised rxd, mid-bit sampling, optional parity, one byte per frame.
// Latency: rxd falling edge to strobe = 2 + CLKS_PER_BIT/2 + (9+PARITY_EN)*CLKS_PER_BIT + 1 clocks.
// Backpressure: none; strobes are single-cycle and downstream must capture rx_data when rx_valid is high.
module uart_rx_frame #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // Wide enough for CLKS_PER_BIT up to 2^20, so the counter never wraps inside a state.
    localparam int CNT_W = 21;
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_rxd_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_par_bit;
    logic             r_stop_bit;
    logic             r_armed;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_parity_err;

    logic w_cnt_end;
    logic w_cnt_half;
    logic w_cnt_clr;
    logic w_shift;
    logic w_par_cap;
    logic w_stop_cap;
    logic w_done;
    logic w_par_err;

    assign w_cnt_end  = (r_cnt == CNT_END);
    assign w_cnt_half = (r_cnt == CNT_HALF);

    // Received parity bit must equal XOR of data (even) or its inverse (odd).
    assign w_par_err = (PARITY_EN != 0) &&
                       (r_par_bit != ((^r_shift) ^ (PARITY_ODD != 0)));

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign busy       = (r_state != S_IDLE);

    // Two-stage synchroniser on the asynchronous line, preset to the idle level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_par_cap   = 1'b0;
        w_stop_cap  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rxd_s && r_armed) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_cnt_half) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_end) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7)
                        w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_cnt_end) begin
                    w_cnt_clr   = 1'b1;
                    w_par_cap   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_cnt_end) begin
                    w_cnt_clr   = 1'b1;
                    w_stop_cap  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_cnt_clr   = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit-period counter, bit index, shift register and captured parity/stop bits.
    // The armed flag blocks a new start while the line is still low after a low stop bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_bit  <= 1'b0;
            r_stop_bit <= 1'b1;
            r_armed    <= 1'b1;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            if (r_state == S_START)
                r_bit_idx <= 3'd0;
            else if (w_shift)
                r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift)    r_shift[r_bit_idx] <= r_rxd_s;
            if (w_par_cap)  r_par_bit          <= r_rxd_s;
            if (w_stop_cap) r_stop_bit         <= r_rxd_s;
            if (w_done)
                r_armed <= r_stop_bit;
            else if (r_rxd_s)
                r_armed <= 1'b1;
        end
    end

    // Result register and single-cycle strobes, issued from the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_done) r_rx_data <= r_shift;
            r_rx_valid   <= w_done && r_stop_bit && !w_par_err;
            r_frame_err  <= w_done && !r_stop_bit;
            r_parity_err <= w_done && w_par_err;
        end
    end

endmodule
